// File: rtl/ama_riscv_scoreboard.sv
// ID-stage scoreboard for long-latency register writers (load misses, divide).
// Tracks busy destination registers and stalls ID on RAW/WAW/capacity hazards.
module ama_riscv_scoreboard #(
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic             issue_long,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             flush,
  input  logic             complete_valid,
  input  logic [4:0]       complete_rd,
  output logic             stall_id,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding,
  output logic             sb_full,
  output logic             err_spurious
);

  logic [31:0]      pend_q;
  logic [31:0]      pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             cap;
  logic             accept;
  logic             comp_hit;
  logic             comp_spur;

  assign sb_full = (cnt_q == CNT_W'(MAX_PENDING));

  // Hazards look only at registered state; pend_q[0] is held at 0 so x0 never hazards.
  assign raw1 = rs1_used & pend_q[rs1_id];
  assign raw2 = rs2_used & pend_q[rs2_id];
  assign waw  = issue_we & pend_q[issue_rd];
  assign cap  = issue_long & issue_we & sb_full;

  assign stall_id = issue_valid & ~flush & (raw1 | raw2 | waw | cap);

  assign accept    = issue_valid & ~flush & ~stall_id & issue_we & issue_long &
                     (issue_rd != '0);
  assign comp_hit  = complete_valid & (complete_rd != '0) & pend_q[complete_rd];
  assign comp_spur = complete_valid & (complete_rd != '0) & ~pend_q[complete_rd];

  always_comb begin
    pend_d = pend_q;
    if (comp_hit) pend_d[complete_rd] = 1'b0;
    if (accept)   pend_d[issue_rd]    = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      // cap keeps accept off when full; comp_hit implies cnt_q >= 1.
      case ({accept, comp_hit})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (comp_spur) err_q <= 1'b1;
    end
  end

  assign pending      = pend_q;
  assign outstanding  = cnt_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_ama_riscv_scoreboard.sv
// Self-checking bench: directed test-plan steps then randomized traffic,
// checked against a queue-of-busy-registers reference model.
module tb_ama_riscv_scoreboard;
  localparam int unsigned MAXP = 4;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_we, issue_long;
  logic [4:0]    issue_rd, rs1_id, rs2_id;
  logic          rs1_used, rs2_used, flush;
  logic          complete_valid;
  logic [4:0]    complete_rd;
  logic          stall_id;
  logic [31:0]   pending;
  logic [CW-1:0] outstanding;
  logic          sb_full;
  logic          err_spurious;

  int checks   = 0;
  int failures = 0;

  int q[$];
  bit m_err;

  ama_riscv_scoreboard #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_long(issue_long),
    .issue_rd(issue_rd), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
    .complete_valid(complete_valid), .complete_rd(complete_rd),
    .stall_id(stall_id), .pending(pending), .outstanding(outstanding),
    .sb_full(sb_full), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  function automatic bit busy(input int r);
    if (r == 0) return 1'b0;
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    foreach (q[i]) v[q[i]] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, we, lg, input int rd, r1, input bit u1,
                     input int r2, input bit u2, fl, cv, input int crd);
    issue_valid = v; issue_we = we; issue_long = lg; issue_rd = 5'(rd);
    rs1_id = 5'(r1); rs1_used = u1; rs2_id = 5'(r2); rs2_used = u2;
    flush = fl; complete_valid = cv; complete_rd = 5'(crd);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare everything against the model, advance the model, then clock.
  task automatic tick(input bit do_chk);
    bit exp_stall, acc;
    #1;
    exp_stall = issue_valid && !flush &&
                ((rs1_used && busy(int'(rs1_id))) || (rs2_used && busy(int'(rs2_id))) ||
                 (issue_we && busy(int'(issue_rd))) ||
                 (issue_long && issue_we && q.size() == MAXP));
    if (do_chk) begin
      chk("stall_id", 32'(stall_id), 32'(exp_stall));
      chk("pending", pending, busy_vec());
      chk("outstanding", 32'(outstanding), 32'(q.size()));
      chk("sb_full", 32'(sb_full), 32'(q.size() == MAXP));
      chk("err_spurious", 32'(err_spurious), 32'(m_err));
    end
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      acc = issue_valid && !flush && !exp_stall && issue_we && issue_long && issue_rd != 0;
      if (complete_valid && complete_rd != 0) begin
        if (busy(int'(complete_rd))) begin
          foreach (q[i]) if (q[i] == int'(complete_rd)) begin q.delete(i); break; end
        end else m_err = 1'b1;
      end
      if (acc) q.push_back(int'(issue_rd));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; m_err = 1'b0; idle();
    tick(0); tick(1);
    rst = 1'b0;
    chk("reset_pending", pending, 32'h0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);

    // Long op to x5, dependent consumer, completion, release one cycle later
    drv(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0); tick(1);
    chk("x5_pending", 32'(pending[5]), 32'd1);
    chk("x5_outstanding", 32'(outstanding), 32'd1);
    drv(1, 1, 0, 10, 5, 1, 0, 0, 0, 0, 0); #1;
    chk("raw_stall", 32'(stall_id), 32'd1);
    tick(1);
    drv(1, 1, 0, 10, 5, 1, 0, 0, 0, 1, 5); #1;
    chk("stall_during_complete", 32'(stall_id), 32'd1);
    tick(1);
    drv(1, 1, 0, 10, 5, 1, 0, 0, 0, 0, 0); #1;
    chk("stall_release", 32'(stall_id), 32'd0);
    chk("x5_cleared", pending, 32'h0);
    tick(1);

    // Fill to capacity with x1..x4
    for (int r = 1; r <= 4; r++) begin
      drv(1, 1, 1, r, 0, 0, 0, 0, 0, 0, 0); tick(1);
    end
    idle(); #1;
    chk("full", 32'(sb_full), 32'd1);
    drv(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("cap_stall", 32'(stall_id), 32'd1);
    drv(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("alu_no_stall", 32'(stall_id), 32'd0);
    tick(1);
    drv(1, 1, 1, 6, 0, 0, 0, 0, 0, 1, 2); tick(1);
    drv(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("cap_released", 32'(stall_id), 32'd0);
    tick(1);
    chk("refilled", 32'(outstanding), 32'd4);
    chk("x6_pending", 32'(pending[6]), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick(1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4); tick(1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6); tick(1);

    // WAW on x7
    drv(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0); tick(1);
    drv(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("waw_stall", 32'(stall_id), 32'd1);
    tick(1);
    drv(1, 1, 0, 7, 0, 0, 0, 0, 0, 1, 7); tick(1);
    drv(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("waw_release", 32'(stall_id), 32'd0);
    tick(1);

    // Same-cycle accept x8 / complete x3 with two outstanding
    drv(1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0); tick(1);
    chk("two_out", 32'(outstanding), 32'd2);
    drv(1, 1, 1, 8, 0, 0, 0, 0, 0, 1, 3); tick(1);
    chk("same_cycle_out", 32'(outstanding), 32'd2);
    chk("same_cycle_bits", 32'({pending[8], pending[3]}), 32'b10);

    // x0 and spurious completion
    drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick(1);
    chk("x0_out", 32'(outstanding), 32'd2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(1);
    chk("x0_complete_no_err", 32'(err_spurious), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); tick(1);
    chk("spurious_err", 32'(err_spurious), 32'd1);
    chk("spurious_out", 32'(outstanding), 32'd2);
    idle(); tick(1);
    chk("err_sticky", 32'(err_spurious), 32'd1);

    // Flush hides the hazard and blocks state change; then reset mid-flight
    drv(1, 1, 1, 13, 8, 1, 0, 0, 1, 0, 0); #1;
    chk("flush_no_stall", 32'(stall_id), 32'd0);
    tick(1);
    chk("flush_no_bit", 32'(pending[13]), 32'd0);
    drv(1, 1, 1, 13, 0, 0, 0, 0, 0, 0, 0); tick(1);
    chk("three_out", 32'(outstanding), 32'd3);
    idle(); rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_pending", pending, 32'h0);
    chk("rst_out", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err_spurious), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 9)), $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) == 0, int'($urandom_range(0, 9)));
      if (complete_valid && q.size() > 0 && $urandom_range(0, 9) != 0)
        complete_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      rst = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 1'b0; idle(); tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ama_riscv_scoreboard.md
Name: ama_riscv_scoreboard

Overview:
- Producer-side hazard tracker in the ID stage for long-latency register writers (load misses, multicycle divide).
- Records destination registers of in-flight long ops.
- Stalls ID while a consumer or WAW-conflicting instruction would read or overwrite a not-yet-written register.
- Releases the register when the long-latency unit reports completion. Fixed-latency results stay on the EX/MEM forwarding paths and are not tracked here.

Parameters:
- MAX_PENDING, 4, maximum outstanding long-latency ops; range 1..31.
- CNT_W, $clog2(MAX_PENDING+1), width of the outstanding-op counter; derived, not overridden.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- issue_valid  input  1  valid instruction in ID
- issue_we  input  1  instruction writes rd
- issue_long  input  1  instruction is long-latency (result via completion port)
- issue_rd  input  5  destination register
- rs1_id  input  5  source 1 index
- rs2_id  input  5  source 2 index
- rs1_used  input  1  instruction reads rs1
- rs2_used  input  1  instruction reads rs2
- flush  input  1  ID instruction is being killed this cycle
- complete_valid  input  1  long-latency unit writes back this cycle
- complete_rd  input  5  register written by completing op
- stall_id  output  1  hold PC/IF/ID, bubble into EX (combinational)
- pending  output  32  busy vector, bit n = xn awaiting long result; bit 0 constant 0
- outstanding  output  CNT_W  number of in-flight long ops
- sb_full  output  1  outstanding == MAX_PENDING
- err_spurious  output  1  sticky, completion for non-pending register

Behaviour:
- Reset (rst=1 at clock edge): pending=0, outstanding=0, err_spurious=0. Reset overrides all same-cycle issue/complete events. Mid-operation reset drops all tracking; the core must flush long units with the same reset.
- x0 handling: rd/rs1/rs2 == 0 never causes a hazard. issue_rd==0 never sets a bit. complete_rd==0 is ignored with no error.
- Hazard terms (combinational on current registered state only; no path from complete_* into stall_id):
  - raw1 = rs1_used & pending[rs1_id]
  - raw2 = rs2_used & pending[rs2_id]
  - waw = issue_we & pending[issue_rd]
  - cap = issue_long & issue_we & sb_full
- stall_id = issue_valid & ~flush & (raw1 | raw2 | waw | cap).
- Accept = issue_valid & ~flush & ~stall_id & issue_we & issue_long & (issue_rd != 0).
- On Accept: pending[issue_rd] <= 1 and outstanding increments.
- Completion: complete_valid & complete_rd!=0 & pending[complete_rd] → pending[complete_rd] <= 0 and outstanding decrements.
- Spurious completion: complete_valid & complete_rd!=0 & ~pending[complete_rd] → err_spurious <= 1; no other state change.
- Accept and completion in the same cycle: outstanding unchanged, both bit updates applied. Same rd in both is impossible, because waw stalls the issue.
- Stall release latency: exactly 1 cycle after the completion cycle. The completion clears the bit at the edge, and stall_id drops the following cycle.
- flush with a hazard: stall_id=0 and no state update. Already in-flight ops stay pending until completion.
- Counter never exceeds MAX_PENDING and never underflows. Spurious completions do not decrement.
- sb_full and outstanding are registered-state derived, with no combinational input dependence.

Test Plan:
- Reset, then issue long op rd=5 → next cycle pending[5]=1, outstanding=1. Dependent op rs1=5, rs1_used=1 → stall_id=1. complete_rd=5 at cycle N → stall_id=0 at N+1, pending=0.
- MAX_PENDING=4: accept long ops to x1..x4 on consecutive cycles → sb_full=1. A 5th long op rd=6 stalls, while a non-long ALU op rd=6 does not. Complete x2 → next cycle the 5th op is accepted and outstanding returns to 4.
- WAW: rd=7 pending, new ALU op writes rd=7 with no source use → stall_id=1 until x7 completes.
- Same-cycle accept rd=8 and complete rd=3 with outstanding=2 → outstanding stays 2, pending[8]=1, pending[3]=0.
- x0 and spurious: long issue rd=0 → pending unchanged and outstanding unchanged. complete_rd=9 with x9 not pending → err_spurious=1 and sticky until rst. complete_rd=0 → no error.
- Flush and reset: hazardous issue with flush=1 → stall_id=0 and no bit set. rst asserted while 3 ops are pending → pending=0, outstanding=0, err_spurious=0 the next cycle.
